socket_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream socket between NUM_REQ upstream sockets.
- Pops words from the granted requester's socket via its read-enable, and forwards them as a registered write stream (data + dv) into the shared downstream socket.
- Honours the downstream full flag and caps each grant at BURST_LEN words so that no requester can starve the others.

---
 rtl/socket_rr_arbiter.sv | 112 +++++++++++
 tb/tb_socket_rr_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/socket_rr_arbiter.sv
// Round-robin arbiter that shares one downstream write socket between NUM_REQ
// upstream read sockets. Grants are capped at BURST_LEN words and released early
// when the owner runs empty.
module socket_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_REQ-1:0]            i_dv,
  output logic [NUM_REQ-1:0]            o_rd_en,
  input  logic                          i_full,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic                          o_dv,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_busy
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IDX_W-1:0]  LAST_INIT = IDX_W'(NUM_REQ - 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX  = BEAT_W'(BURST_LEN - 1);
  localparam logic [IDX_W:0]    NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                  state_q;
  logic [NUM_REQ-1:0]      grant_q;
  logic [IDX_W-1:0]        owner_q;
  logic [IDX_W-1:0]        last_q;
  logic [BEAT_W-1:0]       beat_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    dv_q;

  logic                    found_d;
  logic [IDX_W-1:0]        pick_d;
  logic [IDX_W:0]          cand;
  logic                    owner_dv;
  logic                    xfer;
  logic [DATA_WIDTH-1:0]   owner_word;

  // Search starts just after the previous owner so it is considered last.
  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    found_d = 1'b0;
    pick_d  = '0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_q} + (IDX_W + 1)'(i);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!found_d && i_dv[cand[IDX_W-1:0]]) begin
        found_d = 1'b1;
        pick_d  = cand[IDX_W-1:0];
      end
    end
  end

  assign owner_dv   = i_dv[owner_q];
  assign xfer       = (state_q == GRANT) && owner_dv && !i_full;
  assign owner_word = i_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];

  // Pop strobe is combinational so the requester pops on the same edge that
  // registers its word; grant_q masks it to the single owner.
  assign o_rd_en = (state_q == GRANT && !i_full) ? (grant_q & i_dv) : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here sees the pre-edge value of every other register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= LAST_INIT;
      beat_q  <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      dv_q <= xfer;
      if (xfer) data_q <= owner_word;

      case (state_q)
        IDLE: begin
          if (found_d) begin
            state_q <= GRANT;
            grant_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_d;
            owner_q <= pick_d;
            beat_q  <= '0;
          end
        end
        GRANT: begin
          // An empty owner releases even while stalled by i_full.
          if (!owner_dv || (xfer && beat_q == BEAT_MAX)) begin
            state_q <= IDLE;
            last_q  <= owner_q;
            grant_q <= '0;
            beat_q  <= '0;
          end else if (xfer) begin
            beat_q <= beat_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign o_data  = data_q;
  assign o_dv    = dv_q;
  assign o_grant = grant_q;
  assign o_busy  = (state_q == GRANT);

endmodule

// File: tb/tb_socket_rr_arbiter.sv
// Scoreboard bench for socket_rr_arbiter: directed stimulus pushes hand-computed
// words and inter-word gaps; a negedge monitor pops and compares on every o_dv.
module tb_socket_rr_arbiter;

  typedef struct {
    logic [7:0] data;
    int         gap;   // cycles since previous o_dv; -1 = don't care
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data;
  logic [3:0]  dv;
  logic [3:0]  rd_en;
  logic        full;
  logic [7:0]  odata;
  logic        odv;
  logic [3:0]  grant;
  logic        busy;

  logic [15:0] data2;
  logic [1:0]  dv2;
  logic [1:0]  rd_en2;
  logic [7:0]  odata2;
  logic        odv2;
  logic [1:0]  grant2;
  logic        busy2;

  socket_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_LEN(4)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_data(data), .i_dv(dv), .o_rd_en(rd_en),
    .i_full(full), .o_data(odata), .o_dv(odv), .o_grant(grant), .o_busy(busy)
  );

  socket_rr_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .BURST_LEN(1)) dut2 (
    .i_clk(clk), .i_rst(rst_n), .i_data(data2), .i_dv(dv2), .o_rd_en(rd_en2),
    .i_full(1'b0), .o_data(odata2), .o_dv(odv2), .o_grant(grant2), .o_busy(busy2)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] sock [4][$];
  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [3:0] snap = '0;
  logic       full_v = 1'b0;
  int         cyc = 0;
  int         last_dv_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: registered outputs are stable at the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst_n && odv) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got word 0x%0h expected no write at %0t", odata, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_data", {24'd0, odata}, {24'd0, mon_e.data});
        if (mon_e.gap >= 0) check("sb_gap", cyc - last_dv_cyc, mon_e.gap);
      end
      last_dv_cyc = cyc;
    end
  end

  task automatic apply();
    for (int k = 0; k < 4; k++) begin
      dv[k]         = (sock[k].size() > 0);
      data[k*8 +: 8] = (sock[k].size() > 0) ? sock[k][0] : 8'h00;
    end
    full = full_v;
  endtask

  // One cycle: retire pops seen last cycle, drive new socket heads, snapshot rd_en.
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      if (snap[k] && sock[k].size() > 0) void'(sock[k].pop_front());
    apply();
    #1;
    snap = rd_en;
    check("rd_en_onehot", {31'd0, $onehot0(rd_en)}, 32'd1);
  endtask

  task automatic load(input int k, input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) sock[k].push_back(first + 8'(i));
  endtask

  task automatic expect_w(input logic [7:0] d, input int gap);
    exp_t e;
    e.data = d;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    full_v = 1'b0;
    dv2    = '0;
    for (int k = 0; k < 4; k++) sock[k].delete();
    exp_q.delete();
    snap = '0;
    apply();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || busy || sock[0].size() > 0 || sock[1].size() > 0 ||
            sock[2].size() > 0 || sock[3].size() > 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending words expected 0 after %0d cycles", name, exp_q.size(), budget);
    end
    tick();
    check({name, "_released_grant"}, {28'd0, grant}, 32'd0);
    check({name, "_released_busy"}, {31'd0, busy}, 32'd0);
  endtask

  logic [0:7] b1_dv    = 8'b0101_0101;
  logic [0:7] b1_g0    = 8'b1000_1000;
  logic [0:7] b1_g1    = 8'b0010_0010;
  logic [7:0] b1_data [8] = '{8'h00, 8'hA0, 8'h00, 8'hB1, 8'h00, 8'hA0, 8'h00, 8'hB1};
  logic [0:2] bp_dv    = 3'b100;

  initial begin
    dv2   = '0;
    data2 = '0;
    apply();
    #1;
    check("rst_odv", {31'd0, odv}, 32'd0);
    check("rst_odata", {24'd0, odata}, 32'd0);
    check("rst_grant", {28'd0, grant}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rd_en", {28'd0, rd_en}, 32'd0);

    // Single requester, 6 words: burst of 4, one bubble, regrant for 2.
    do_reset();
    load(1, 8'h11, 6);
    expect_w(8'h11, -1); expect_w(8'h12, 1); expect_w(8'h13, 1); expect_w(8'h14, 1);
    expect_w(8'h15, 2);  expect_w(8'h16, 1);
    tick();
    check("single_bubble_grant", {28'd0, grant}, 32'd0);
    check("single_bubble_rd_en", {28'd0, rd_en}, 32'd0);
    tick();
    check("single_grant", {28'd0, grant}, 32'b0010);
    check("single_busy", {31'd0, busy}, 32'd1);
    drain("single", 40);

    // All four requesting: order 0,1,2,3,0 with 4 words each.
    do_reset();
    load(0, 8'h01, 8); load(1, 8'h11, 4); load(2, 8'h21, 4); load(3, 8'h31, 4);
    for (int g = 0; g < 5; g++) begin
      logic [7:0] base;
      base = (g == 4) ? 8'h05 : (8'(g) << 4) + 8'h01;
      for (int w = 0; w < 4; w++)
        expect_w(base + 8'(w), (w != 0) ? 1 : (g == 0) ? -1 : 2);
    end
    drain("all4", 80);

    // Backpressure on requester 2 after its 2nd transfer.
    do_reset();
    load(2, 8'h21, 4);
    expect_w(8'h21, -1); expect_w(8'h22, 1); expect_w(8'h23, 4); expect_w(8'h24, 1);
    repeat (3) tick();
    full_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_rd_en", {28'd0, rd_en}, 32'd0);
      check("bp_odv", {31'd0, odv}, {31'd0, bp_dv[i]});
      check("bp_grant_held", {28'd0, grant}, 32'b0100);
    end
    full_v = 1'b0;
    drain("bp", 40);

    // Early empty on requester 3, then search restarts at requester 0.
    do_reset();
    load(3, 8'h31, 2);
    expect_w(8'h31, -1); expect_w(8'h32, 1); expect_w(8'h01, 3); expect_w(8'h02, 1);
    expect_w(8'h11, 3);
    tick();
    load(0, 8'h01, 2);
    load(1, 8'h11, 1);
    tick();
    check("early_grant3", {28'd0, grant}, 32'b1000);
    drain("early", 40);

    // Reset mid-burst after the 2nd word.
    do_reset();
    load(0, 8'h01, 4); load(1, 8'h11, 4); load(2, 8'h21, 4); load(3, 8'h31, 4);
    expect_w(8'h01, -1); expect_w(8'h02, 1);
    repeat (4) tick();
    check("midrst_pre_busy", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_odv", {31'd0, odv}, 32'd0);
    check("midrst_odata", {24'd0, odata}, 32'd0);
    check("midrst_grant", {28'd0, grant}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_rd_en", {28'd0, rd_en}, 32'd0);
    check("midrst_sb_empty", exp_q.size(), 32'd0);
    do_reset();
    load(0, 8'h0A, 1); load(1, 8'h1A, 1); load(2, 8'h2A, 1); load(3, 8'h3A, 1);
    expect_w(8'h0A, -1); expect_w(8'h1A, 3); expect_w(8'h2A, 3); expect_w(8'h3A, 3);
    tick();
    tick();
    check("midrst_first_grant", {28'd0, grant}, 32'b0001);
    drain("midrst", 40);

    // BURST_LEN=1, two requesters: alternate 0,1 with one bubble each.
    do_reset();
    dv2   = 2'b11;
    data2 = {8'hB1, 8'hA0};
    for (int i = 0; i < 8; i++) begin
      tick();
      check("b1_odv", {31'd0, odv2}, {31'd0, b1_dv[i]});
      check("b1_grant", {30'd0, grant2}, {30'd0, b1_g1[i], b1_g0[i]});
      if (b1_dv[i]) check("b1_data", {24'd0, odata2}, {24'd0, b1_data[i]});
    end
    dv2 = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no summary expected finish before 200000");
    $fatal(1);
  end

endmodule
